// File: rtl/rr_burst_arbiter_if.sv
// Handshake bundle between the source FIFOs, the round-robin burst arbiter and the sink writer.
// The arbiter takes the slave view; the driving environment takes the master view.
interface rr_burst_arbiter_if #(
   parameter int N  = 7,
   parameter int DW = 32,
   parameter int CW = 3
);
   logic [N-1:0]    WRITE_REQ;
   logic [N-1:0]    HOLD_REQ;
   logic [N-1:0]    EN_MASK;
   logic [N*DW-1:0] DATA_IN;
   logic [N-1:0]    READ_GRANT;
   logic            READY_OUT;
   logic            WRITE_OUT;
   logic [DW-1:0]   DATA_OUT;
   logic [CW-1:0]   CH_OUT;
   logic [CW-1:0]   OWNER;
   logic            BUSY;

   modport master (
      output WRITE_REQ, HOLD_REQ, EN_MASK, DATA_IN, READY_OUT,
      input  READ_GRANT, WRITE_OUT, DATA_OUT, CH_OUT, OWNER, BUSY
   );

   modport slave (
      input  WRITE_REQ, HOLD_REQ, EN_MASK, DATA_IN, READY_OUT,
      output READ_GRANT, WRITE_OUT, DATA_OUT, CH_OUT, OWNER, BUSY
   );
endinterface

// File: rtl/rr_burst_arbiter.sv
// N-channel round-robin arbiter with bounded bursts, enable mask and HOLD preemption,
// merging FWFT source FIFOs into one registered, channel-tagged output stream.
module rr_burst_arbiter #(
   parameter int N         = 7,
   parameter int DW        = 32,
   parameter int MAX_BURST = 16,
   parameter int CW        = 3
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST,
   rr_burst_arbiter_if.slave   bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] owner_q, owner_d;
   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]   burst_cnt_q, burst_cnt_d;
   logic          write_out_q, write_out_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] ch_q, ch_d;

   logic [N-1:0]  elig, hold_elig;
   logic [CW-1:0] pick;
   int            best;
   logic [DW-1:0] own_data;
   logic          own_wreq, own_hold, own_en;
   logic          slot_free, pop, limit_hit, release_own;
   logic [15:0]   cnt_next;

   // HOLD requesters win by lowest index; otherwise nearest eligible channel after the pointer.
   always_comb begin
      elig      = bus.EN_MASK & (bus.WRITE_REQ | bus.HOLD_REQ);
      hold_elig = elig & bus.HOLD_REQ;
      pick      = '0;
      best      = N;
      for (int i = N-1; i >= 0; i--)
         if (hold_elig[i]) pick = CW'(i);
      if (hold_elig == '0) begin
         for (int i = 0; i < N; i++) begin
            if (elig[i] && ((i + N - 1 - int'(rr_ptr_q)) % N) < best) begin
               best = (i + N - 1 - int'(rr_ptr_q)) % N;
               pick = CW'(i);
            end
         end
      end
   end

   always_comb begin
      own_data = '0;
      for (int i = 0; i < N; i++)
         if (owner_q == CW'(i)) own_data = bus.DATA_IN[i*DW +: DW];
   end

   assign own_wreq  = bus.WRITE_REQ[owner_q];
   assign own_hold  = bus.HOLD_REQ[owner_q];
   assign own_en    = bus.EN_MASK[owner_q];
   assign slot_free = !write_out_q || bus.READY_OUT;
   assign pop       = (state_q == GRANT) && own_wreq && own_en && slot_free;
   assign cnt_next  = (burst_cnt_q == 16'hFFFF) ? burst_cnt_q : burst_cnt_q + 16'd1;
   assign limit_hit = (MAX_BURST != 0) && pop && ((int'(burst_cnt_q) + 1) >= MAX_BURST);
   // Losing the enable drops the grant even under HOLD.
   assign release_own = !own_en || (!own_hold && (!own_wreq || limit_hit));

   always_comb begin
      bus.READ_GRANT = '0;
      if (pop && !BUS_RST) bus.READ_GRANT = N'(1) << owner_q;
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      write_out_d = write_out_q;
      data_d      = data_q;
      ch_d        = ch_q;
      case (state_q)
         IDLE: begin
            if (elig != '0) begin
               state_d     = GRANT;
               owner_d     = pick;
               burst_cnt_d = '0;
            end
         end
         default: begin
            if (pop) burst_cnt_d = cnt_next;
            if (release_own) begin
               state_d  = IDLE;
               rr_ptr_d = owner_q;
            end
         end
      endcase
      if (pop) begin
         write_out_d = 1'b1;
         data_d      = own_data;
         ch_d        = owner_q;
      end else if (bus.READY_OUT) begin
         write_out_d = 1'b0;
      end
   end

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= CW'(N-1);
         burst_cnt_q <= '0;
         write_out_q <= 1'b0;
         data_q      <= '0;
         ch_q        <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         write_out_q <= write_out_d;
         data_q      <= data_d;
         ch_q        <= ch_d;
      end
   end

   assign bus.WRITE_OUT = write_out_q;
   assign bus.DATA_OUT  = data_q;
   assign bus.CH_OUT    = ch_q;
   assign bus.OWNER     = owner_q;
   assign bus.BUSY      = (state_q == GRANT);
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: per-cycle vector table, directed multi-cycle scenarios
// against FIFO queues, randomized traffic with a rule-based scoreboard, and an unlimited-burst instance.
module tb_rr_burst_arbiter;
   localparam int N = 7, DW = 32, CW = 3, MB = 4;

   logic BUS_CLK = 1'b0;
   logic BUS_RST = 1'b1;
   always #5 BUS_CLK = ~BUS_CLK;

   rr_burst_arbiter_if #(.N(N), .DW(DW), .CW(CW)) bus ();
   rr_burst_arbiter_if #(.N(2), .DW(DW), .CW(1))  bus2 ();

   rr_burst_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB), .CW(CW)) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .bus(bus));
   rr_burst_arbiter #(.N(2), .DW(DW), .MAX_BURST(0), .CW(1)) dut2 (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .bus(bus2));

   int passed = 0, total = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   typedef struct {
      logic [6:0] wreq, hold, en;
      logic       rdy;
      logic [6:0] g;
      logic       wo;
      logic [2:0] ch, own;
      logic       busy;
   } vec_t;
   vec_t tv[16];

   // Source FIFO model: words stay in mem so the scoreboard can replay them in order.
   logic [31:0] mem [N][64];
   int head[N], tail[N], chk_i[N];
   int out_ch[512], t_acc[512];
   int n_out, cyc, sb_err, viol_mask, viol_onehot, viol_burst, run;
   logic [6:0] hold_v, en_v, s_g;
   logic s_wo, s_b;
   logic [31:0] s_d;
   logic [2:0] s_own;

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; chk_i[i] = 0; end
      n_out = 0; cyc = 0; sb_err = 0; viol_mask = 0; viol_onehot = 0; viol_burst = 0; run = 0;
   endtask

   task automatic do_reset();
      BUS_RST = 1'b1;
      @(posedge BUS_CLK); #1;
      BUS_RST = 1'b0;
      clear_model();
   endtask

   task automatic push(input int ch, input int n, input int tag);
      for (int k = 0; k < n; k++) begin
         if (tail[ch] < 64) begin
            mem[ch][tail[ch]] = {8'(tag), 8'(ch), 16'(tail[ch])};
            tail[ch]++;
         end
      end
   endtask

   // Direct-drive cycle for the vector table.
   task automatic tdrive(input logic [6:0] w, input logic [6:0] h, input logic [6:0] e, input logic r);
      bus.WRITE_REQ = w; bus.HOLD_REQ = h; bus.EN_MASK = e; bus.READY_OUT = r;
      for (int i = 0; i < N; i++) bus.DATA_IN[i*DW +: DW] = 32'hC0DE0000 | 32'(i);
      #1;
      s_g = bus.READ_GRANT;
      @(posedge BUS_CLK); #1;
   endtask

   // FIFO-mode cycle: present heads, sample pre-edge, log accepted words, pop granted channel.
   task automatic fstep(input logic rdy);
      int c;
      for (int i = 0; i < N; i++) begin
         bus.WRITE_REQ[i] = (head[i] < tail[i]);
         bus.DATA_IN[i*DW +: DW] = (head[i] < tail[i]) ? mem[i][head[i]] : 32'h0;
      end
      bus.HOLD_REQ = hold_v; bus.EN_MASK = en_v; bus.READY_OUT = rdy;
      #1;
      s_g = bus.READ_GRANT; s_wo = bus.WRITE_OUT; s_d = bus.DATA_OUT;
      s_b = bus.BUSY; s_own = bus.OWNER;
      if ($countones(s_g) > 1) viol_onehot++;
      if ((s_g & ~en_v) != 0) viol_mask++;
      if (!s_b) run = 0;
      else if (s_g != 0) begin
         run++;
         if (run > MB && !hold_v[s_own]) viol_burst++;
      end
      if (s_wo && rdy) begin
         c = int'(bus.CH_OUT);
         if (c >= N || chk_i[c] >= tail[c] || s_d !== mem[c][chk_i[c]]) sb_err++;
         if (c < N) chk_i[c]++;
         if (n_out < 512) begin out_ch[n_out] = c; t_acc[n_out] = cyc; end
         n_out++;
      end
      @(posedge BUS_CLK); #1;
      for (int i = 0; i < N; i++) if (s_g[i]) head[i]++;
      cyc++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_seq[20];
      int k, bad, tot_in, np, ng, tf, tl, bad2;
      logic [31:0] held_d;
      logic [1:0] g2;

      bus.WRITE_REQ = '0; bus.HOLD_REQ = '0; bus.EN_MASK = '1; bus.DATA_IN = '0; bus.READY_OUT = 1'b1;
      bus2.WRITE_REQ = '0; bus2.HOLD_REQ = '0; bus2.EN_MASK = '1; bus2.DATA_IN = '0; bus2.READY_OUT = 1'b1;
      hold_v = '0; en_v = '1;
      clear_model();

      #1;
      chk("rst WRITE_OUT", bus.WRITE_OUT, 0);
      chk("rst DATA_OUT", bus.DATA_OUT, 0);
      chk("rst CH_OUT", bus.CH_OUT, 0);
      chk("rst OWNER", bus.OWNER, 0);
      chk("rst BUSY", bus.BUSY, 0);
      chk("rst READ_GRANT", bus.READ_GRANT, 0);
      @(posedge BUS_CLK); #1;
      BUS_RST = 1'b0;

      // wreq, hold, en, rdy | grant (pre-edge), wo, ch, owner, busy (post-edge)
      tv[0]  = '{7'h02, 7'h00, 7'h7F, 1'b1, 7'h00, 1'b0, 3'd0, 3'd1, 1'b1};
      tv[1]  = '{7'h02, 7'h00, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 3'd1, 1'b1};
      tv[2]  = '{7'h02, 7'h00, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 3'd1, 1'b1};
      tv[3]  = '{7'h02, 7'h00, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 3'd1, 1'b1};
      tv[4]  = '{7'h02, 7'h00, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 3'd1, 1'b0};
      tv[5]  = '{7'h0A, 7'h00, 7'h7F, 1'b1, 7'h00, 1'b0, 3'd1, 3'd3, 1'b1};
      tv[6]  = '{7'h0A, 7'h00, 7'h7F, 1'b0, 7'h08, 1'b1, 3'd3, 3'd3, 1'b1};
      tv[7]  = '{7'h0A, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd3, 3'd3, 1'b1};
      tv[8]  = '{7'h0A, 7'h00, 7'h77, 1'b0, 7'h00, 1'b1, 3'd3, 3'd3, 1'b0};
      tv[9]  = '{7'h0A, 7'h00, 7'h77, 1'b1, 7'h00, 1'b0, 3'd3, 3'd1, 1'b1};
      tv[10] = '{7'h02, 7'h01, 7'h77, 1'b1, 7'h02, 1'b1, 3'd1, 3'd1, 1'b1};
      tv[11] = '{7'h00, 7'h01, 7'h77, 1'b1, 7'h00, 1'b0, 3'd1, 3'd1, 1'b0};
      tv[12] = '{7'h00, 7'h01, 7'h77, 1'b1, 7'h00, 1'b0, 3'd1, 3'd0, 1'b1};
      tv[13] = '{7'h00, 7'h01, 7'h77, 1'b1, 7'h00, 1'b0, 3'd1, 3'd0, 1'b1};
      tv[14] = '{7'h01, 7'h01, 7'h77, 1'b1, 7'h01, 1'b1, 3'd0, 3'd0, 1'b1};
      tv[15] = '{7'h00, 7'h00, 7'h77, 1'b1, 7'h00, 1'b0, 3'd0, 3'd0, 1'b0};
      for (int r = 0; r < 16; r++) begin
         tdrive(tv[r].wreq, tv[r].hold, tv[r].en, tv[r].rdy);
         chk($sformatf("row%0d grant", r), s_g, tv[r].g);
         chk($sformatf("row%0d wo", r), bus.WRITE_OUT, tv[r].wo);
         chk($sformatf("row%0d ch", r), bus.CH_OUT, tv[r].ch);
         chk($sformatf("row%0d owner", r), bus.OWNER, tv[r].own);
         chk($sformatf("row%0d busy", r), bus.BUSY, tv[r].busy);
         if (tv[r].wo) chk($sformatf("row%0d data", r), bus.DATA_OUT, 32'hC0DE0000 | 32'(tv[r].ch));
      end

      // Async reset while a word sits in the output register.
      tdrive(7'h03, 7'h00, 7'h7F, 1'b1);
      tdrive(7'h03, 7'h00, 7'h7F, 1'b1);
      chk("t5 pre wo", bus.WRITE_OUT, 1);
      chk("t5 pre busy", bus.BUSY, 1);
      #2; BUS_RST = 1'b1; #1;
      chk("t5 async wo", bus.WRITE_OUT, 0);
      chk("t5 async data", bus.DATA_OUT, 0);
      chk("t5 async ch", bus.CH_OUT, 0);
      chk("t5 async busy", bus.BUSY, 0);
      chk("t5 async grant", bus.READ_GRANT, 0);
      @(posedge BUS_CLK); #1; BUS_RST = 1'b0;
      tdrive(7'h03, 7'h00, 7'h7F, 1'b1);
      chk("t5 first owner", bus.OWNER, 0);
      chk("t5 first busy", bus.BUSY, 1);

      // T1: two channels x 10 words, limit 4.
      do_reset(); hold_v = '0; en_v = '1;
      push(1, 10, 1); push(3, 10, 1);
      for (int i = 0; i < 200 && n_out < 20; i++) fstep(1'b1);
      k = 0;
      for (int b = 0; b < 4; b++) for (int j = 0; j < 4; j++) begin exp_seq[k] = (b % 2) ? 3 : 1; k++; end
      exp_seq[16] = 1; exp_seq[17] = 1; exp_seq[18] = 3; exp_seq[19] = 3;
      bad = 0;
      for (int i = 0; i < 20; i++) if (out_ch[i] != exp_seq[i]) bad++;
      chk("t1 count", n_out, 20);
      chk("t1 ch sequence errors", bad, 0);
      chk("t1 span to word16", t_acc[16] - t_acc[0], 20);
      chk("t1 scoreboard", sb_err, 0);

      // T2: HOLD channel preempts at the next arbitration and keeps an empty grant.
      do_reset(); hold_v = '0; en_v = '1;
      push(2, 12, 2);
      fstep(1'b1); fstep(1'b1);
      hold_v[0] = 1'b1; push(0, 3, 2);
      for (int i = 0; i < 50 && head[0] < 3; i++) fstep(1'b1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         fstep(1'b1);
         if (!s_b || s_own != 3'd0 || s_g != 0) bad++;
      end
      chk("t2 hold keeps empty grant", bad, 0);
      hold_v = '0;
      for (int i = 0; i < 100 && n_out < 15; i++) fstep(1'b1);
      bad = 0;
      for (int i = 0; i < 15; i++) if (out_ch[i] != ((i >= 4 && i < 7) ? 0 : 2)) bad++;
      chk("t2 count", n_out, 15);
      chk("t2 ch order errors", bad, 0);
      chk("t2 scoreboard", sb_err, 0);

      // T3: sink stall mid-burst.
      do_reset();
      push(4, 8, 3);
      fstep(1'b1); fstep(1'b1); fstep(1'b1);
      bad = 0; held_d = '0;
      for (int i = 0; i < 5; i++) begin
         fstep(1'b0);
         if (i == 0) held_d = s_d;
         if (s_g != 0 || !s_wo || s_d !== held_d) bad++;
      end
      chk("t3 stall stable", bad, 0);
      for (int i = 0; i < 50 && n_out < 8; i++) fstep(1'b1);
      chk("t3 count", n_out, 8);
      chk("t3 scoreboard", sb_err, 0);

      // T4: owner masked mid-burst.
      do_reset();
      push(1, 8, 4); push(5, 8, 4);
      fstep(1'b1); fstep(1'b1); fstep(1'b1);
      en_v[1] = 1'b0;
      fstep(1'b1);
      chk("t4 no pop after mask", s_g, 0);
      for (int i = 0; i < 100 && n_out < 10; i++) fstep(1'b1);
      chk("t4 ch1 pops", head[1], 2);
      chk("t4 count", n_out, 10);
      chk("t4 scoreboard", sb_err, 0);
      chk("t4 masked grant", viol_mask, 0);
      en_v = '1;

      // Randomized traffic: random fill, sink stalls, mask flips; then drain.
      do_reset(); hold_v = '0; en_v = '1;
      for (int ch = 0; ch < N; ch++) push(ch, $urandom_range(0, 20), 5);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            k = $urandom_range(0, N-1);
            en_v[k] = ~en_v[k];
         end
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, N-1);
            if (tail[k] < 60) push(k, 1, 5);
         end
         fstep($urandom_range(0, 3) != 0);
      end
      en_v = '1;
      tot_in = 0;
      for (int ch = 0; ch < N; ch++) tot_in += tail[ch];
      for (int i = 0; i < 800 && n_out < tot_in; i++) fstep(1'b1);
      chk("rnd all delivered", n_out, tot_in);
      chk("rnd scoreboard", sb_err, 0);
      chk("rnd one-hot grant", viol_onehot, 0);
      chk("rnd masked grant", viol_mask, 0);
      chk("rnd burst limit", viol_burst, 0);

      // T6: unlimited burst instance, 100 words back-to-back.
      do_reset();
      np = 0; ng = 0; tf = -1; tl = -1; bad2 = 0;
      for (int c2 = 0; c2 < 400 && ng < 100; c2++) begin
         bus2.WRITE_REQ = {1'b0, np < 100};
         bus2.DATA_IN = {32'h0, 32'(np)};
         bus2.READY_OUT = 1'b1; bus2.EN_MASK = 2'b11; bus2.HOLD_REQ = 2'b00;
         #1;
         g2 = bus2.READ_GRANT;
         if (bus2.WRITE_OUT) begin
            if (bus2.DATA_OUT !== 32'(ng)) bad2++;
            if (ng == 0) tf = c2;
            tl = c2;
            ng++;
         end
         @(posedge BUS_CLK); #1;
         if (g2[0]) np++;
      end
      bus2.WRITE_REQ = '0;
      @(posedge BUS_CLK); #1;
      chk("t6 count", ng, 100);
      chk("t6 no gaps", tl - tf, 99);
      chk("t6 data order", bad2, 0);
      chk("t6 released on empty", bus2.BUSY, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
